// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction
// fetch port and the data (load/store) port. One access is in flight at a time.
// Each access is sequenced for a fixed RAM latency. Completion is signalled by
// a one-cycle valid pulse. stall_o holds the pipeline while a request is open.
// Optional feature: define ARB_RR_EN to make the arbiter alternate grants on
// simultaneous requests. Without it, the data port always wins a tie.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_valid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_ce_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_valid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              stall_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                gnt_q, gnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                sel_data;
`ifdef ARB_RR_EN
   logic                last_gnt_q, last_gnt_d;
`endif

   // Pick the winner of the next grant: data first, or alternating on a tie.
   always_comb begin
      sel_data = d_ce_i;
`ifdef ARB_RR_EN
      if (d_ce_i && if_req_i) begin
         sel_data = ~last_gnt_q;
      end
`endif
   end

   // Next-state logic: grant in IDLE, count out the latency in ACCESS, pulse in RESP.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
`ifdef ARB_RR_EN
      last_gnt_d = last_gnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (d_ce_i || if_req_i) begin
               gnt_d   = sel_data;
               addr_d  = sel_data ? d_addr_i : if_addr_i;
               we_d    = sel_data & d_we_i;
               wdata_d = sel_data ? d_wdata_i : '0;
               cnt_d   = '0;
               state_d = ACCESS;
`ifdef ARB_RR_EN
               last_gnt_d = sel_data;
`endif
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               if (!gnt_q) begin
                  if_rdata_d = ram_rdata_i;
               end else if (!we_q) begin
                  d_rdata_d = ram_rdata_i;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         gnt_q      <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
`ifdef ARB_RR_EN
         last_gnt_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
`ifdef ARB_RR_EN
         last_gnt_q <= last_gnt_d;
`endif
      end
   end

   assign ram_ce_o    = (state_q == ACCESS);
   assign ram_we_o    = (state_q == ACCESS) & we_q;
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;
   assign if_valid_o  = (state_q == RESP) & ~gnt_q;
   assign d_valid_o   = (state_q == RESP) & gnt_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign stall_o     = ~rst & ((d_ce_i & ~d_valid_o) | (if_req_i & ~if_valid_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter with LATENCY=2 and a small registered RAM model.
// The expected arbitration order follows ARB_RR_EN when it is defined.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        d_ce = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic        stall;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;

   logic        tb_wr = 1'b0;
   logic [9:0]  tb_waddr = '0;
   logic [31:0] tb_wdata = '0;
   logic [31:0] mem [0:1023];

   int tests_run = 0;
   int tests_failed = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid), .if_rdata_o(if_rdata),
      .d_ce_i(d_ce), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_valid_o(d_valid), .d_rdata_o(d_rdata), .stall_o(stall),
      .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
      .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   // Registered RAM model: writes when ce&we, read data appears one edge later.
   always @(posedge clk) begin
      if (tb_wr) mem[tb_waddr] <= tb_wdata;
      else if (ram_ce && ram_we) mem[ram_addr[9:0]] <= ram_wdata;
      ram_rdata <= mem[ram_addr[9:0]];
   end

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if ({ram_ce, ram_we, ram_addr, ram_wdata, if_valid, d_valid, if_rdata, d_rdata, stall} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got ce=%b we=%b addr=%h wd=%h iv=%b dv=%b ir=%h dr=%h st=%b, want all 0",
                  ram_ce, ram_we, ram_addr, ram_wdata, if_valid, d_valid, if_rdata, d_rdata, stall);
      end
      // Preload the fetch word while still in reset.
      @(posedge clk); #1;
      tb_wr = 1'b1; tb_waddr = 10'h010; tb_wdata = 32'h00A00093;
      @(posedge clk); #1;
      tb_wr = 1'b0; rst = 1'b0;
   endtask

   task automatic test_fetch();
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h10;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests_run++;
         if ({ram_ce, if_valid, stall} !== {(k == 1 || k == 2), (k == 3), (k < 3)}) begin
            tests_failed++;
            $display("[TB] FAIL fetch_cycle%0d: got ce=%b iv=%b st=%b, want ce=%b iv=%b st=%b",
                     k, ram_ce, if_valid, stall, (k == 1 || k == 2), (k == 3), (k < 3));
         end
         @(posedge clk); #1;
         if (k == 3) if_req = 1'b0;
      end
      tests_run++;
      if (if_rdata !== 32'h00A00093) begin
         tests_failed++;
         $display("[TB] FAIL fetch_rdata: got %h want 00a00093", if_rdata);
      end
   endtask

   task automatic test_store();
      d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests_run++;
         if (k == 1 || k == 2) begin
            if ({ram_ce, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
               tests_failed++;
               $display("[TB] FAIL store_ram%0d: got ce=%b we=%b addr=%h wd=%h, want 1 1 100 deadbeef",
                        k, ram_ce, ram_we, ram_addr, ram_wdata);
            end
         end else if ({d_valid, if_valid, stall} !== {(k == 3), 1'b0, (k < 3)}) begin
            tests_failed++;
            $display("[TB] FAIL store_cycle%0d: got dv=%b iv=%b st=%b, want dv=%b iv=0 st=%b",
                     k, d_valid, if_valid, stall, (k == 3), (k < 3));
         end
         @(posedge clk); #1;
         if (k == 3) d_ce = 1'b0;
      end
      tests_run++;
      if (d_rdata !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL store_rdata_held: got %h want 00000000", d_rdata);
      end
      tests_run++;
      if (mem[10'h100] !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL store_mem: got %h want deadbeef", mem[10'h100]);
      end
   endtask

   task automatic test_load();
      d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests_run++;
         if ({d_valid, ram_we, ram_ce} !== {(k == 3), 1'b0, (k == 1 || k == 2)}) begin
            tests_failed++;
            $display("[TB] FAIL load_cycle%0d: got dv=%b we=%b ce=%b, want dv=%b we=0 ce=%b",
                     k, d_valid, ram_we, ram_ce, (k == 3), (k == 1 || k == 2));
         end
         if (k == 3) begin
            tests_run++;
            if (d_rdata !== 32'hDEADBEEF) begin
               tests_failed++;
               $display("[TB] FAIL load_rdata: got %h want deadbeef", d_rdata);
            end
         end
         @(posedge clk); #1;
         if (k == 3) d_ce = 1'b0;
      end
   endtask

   task automatic test_reset_mid_access();
      if_req = 1'b1; if_addr = 32'h10;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (ram_ce !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midrst_pre_ce: got %b want 1", ram_ce);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({ram_ce, ram_we, ram_addr, if_valid, d_valid, if_rdata, d_rdata, stall} !== '0) begin
         tests_failed++;
         $display("[TB] FAIL midrst_outputs: got ce=%b addr=%h iv=%b dv=%b ir=%h dr=%h st=%b, want all 0",
                  ram_ce, ram_addr, if_valid, d_valid, if_rdata, d_rdata, stall);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests_run++;
         if ({ram_ce, if_valid, stall} !== {(k == 1 || k == 2), (k == 3), (k < 3)}) begin
            tests_failed++;
            $display("[TB] FAIL midrst_after%0d: got ce=%b iv=%b st=%b, want ce=%b iv=%b st=%b",
                     k, ram_ce, if_valid, stall, (k == 1 || k == 2), (k == 3), (k < 3));
         end
         @(posedge clk); #1;
         if (k == 3) if_req = 1'b0;
      end
      tests_run++;
      if (if_rdata !== 32'h00A00093) begin
         tests_failed++;
         $display("[TB] FAIL midrst_rdata: got %h want 00a00093", if_rdata);
      end
   endtask

   task automatic test_simultaneous();
      logic exp_port [4];
      int   nev;
`ifdef ARB_RR_EN
      exp_port = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_port = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      nev = 0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h10;
      d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (if_valid && d_valid) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL tie_both_valid: cycle %0d got both valids high, want at most one", k);
         end else if (if_valid || d_valid) begin
            tests_run++;
            if (nev >= 4 || k != 3 + 4 * nev || d_valid !== exp_port[nev]) begin
               tests_failed++;
               $display("[TB] FAIL tie_event%0d: got port=%b at cycle %0d, want port=%b at cycle %0d",
                        nev, d_valid, k, (nev < 4) ? exp_port[nev] : 1'b0, 3 + 4 * nev);
            end
            nev++;
         end
         @(posedge clk); #1;
      end
      if_req = 1'b0; d_ce = 1'b0;
      tests_run++;
      if (nev != 4) begin
         tests_failed++;
         $display("[TB] FAIL tie_count: got %0d completions want 4", nev);
      end
   endtask

   task automatic test_back_to_back();
      int  nv;
      logic prev;
      nv = 0; prev = 1'b0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h10;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         tests_run++;
         if (if_valid !== ((k % 4) == 3) || (prev && if_valid)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_cycle%0d: got iv=%b (prev %b) want iv=%b", k, if_valid, prev, ((k % 4) == 3));
         end
         if (if_valid) nv++;
         prev = if_valid;
         @(posedge clk); #1;
      end
      if_req = 1'b0;
      tests_run++;
      if (nv != 3) begin
         tests_failed++;
         $display("[TB] FAIL b2b_count: got %0d valids want 3", nv);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_load();
      test_reset_mid_access();
      test_simultaneous();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
